// File: rtl/sr_dmem_if.sv
// sr_dmem_if: request/response bus between the load/store unit and sr_dmem.
//
// Both channels use strict valid/ready: a beat transfers on a rising edge
// where valid && ready are both high. Once the producer raises valid, it
// holds valid and all payload fields stable until that edge. The consumer
// may drive ready independently of valid.
interface sr_dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Load/store unit side.
  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Memory side.
  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sr_dmem.sv
// sr_dmem: word-organised data memory with byte lanes, programmable wait
// states and range/size checking.
//
// Each request runs IDLE -> WAIT -> BEAT0 [-> BEAT1] -> RESP. Requests that
// fail a check still walk the same path so that latency does not depend on
// the outcome; they just skip the memory operation.
//
// Optional feature macro: SR_DMEM_SPLIT_EN. When defined, an access that
// crosses a word boundary runs as two beats (word i, then word i+1). When
// undefined, such an access is answered with rsp_err and BEAT1 is never used.
//
// dbg_state exposes the FSM state encoding for checkers.
module sr_dmem #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  sr_dmem_if.slave       bus,
  output logic [2:0]     dbg_state
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_BEAT0 = 3'd2,
    ST_BEAT1 = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            sign_q, sign_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      off_q, off_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [31:0]     mem [DEPTH];

  // Accept-time checks.
  logic            accept;
  logic [2:0]      req_len;
  logic [32:0]     last_byte;
  logic            misaligned;
  logic            req_err;

  // Beat-time lane selection for the captured request.
  logic [3:0]      len_mask;
  logic [3:0]      be0;
  logic [31:0]     wr0;
  logic [31:0]     rd0;

`ifdef SR_DMEM_SPLIT_EN
  logic            split_q, split_d;
  logic [31:0]     lo_q, lo_d;
  logic [AW-1:0]   idx_hi;
  logic [7:0]      mask8;
  logic [63:0]     wd64;
  logic [3:0]      be1;
  logic [31:0]     wr1;
  logic [31:0]     rd1;
`endif

  // Extract the addressed bytes from a (possibly two-word) raw read and
  // extend to 32 bits. Word loads are returned as-is.
  function automatic logic [31:0] load_result(input logic [63:0] raw,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size,
                                              input logic        sign);
    logic [31:0] s;
    logic [31:0] r;
    s = 32'(raw >> {off, 3'b000});
    case (size)
      2'b00:   r = sign ? {{24{s[7]}}, s[7:0]}   : {24'b0, s[7:0]};
      2'b01:   r = sign ? {{16{s[15]}}, s[15:0]} : {16'b0, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  // Request length and range/alignment checks on the live request fields.
  always_comb begin
    accept = bus.req_valid && (state_q == ST_IDLE);
    case (bus.req_size)
      2'b00:   req_len = 3'd1;
      2'b01:   req_len = 3'd2;
      default: req_len = 3'd4;
    endcase
    // 33-bit sum so an access wrapping past 0xFFFFFFFF is still out of range.
    last_byte  = {1'b0, bus.req_addr} + 33'(req_len) - 33'd1;
    misaligned = ({1'b0, bus.req_addr[1:0]} + req_len) > 3'd4;
    req_err    = (bus.req_size == 2'b11) || (last_byte >= MEM_BYTES);
`ifndef SR_DMEM_SPLIT_EN
    req_err    = req_err || misaligned;
`endif
  end

  // Byte enables and lane-shifted store data for the captured request.
  always_comb begin
    case (size_q)
      2'b00:   len_mask = 4'b0001;
      2'b01:   len_mask = 4'b0011;
      default: len_mask = 4'b1111;
    endcase
    rd0 = mem[idx_q];
`ifdef SR_DMEM_SPLIT_EN
    idx_hi = idx_q + AW'(1);
    rd1    = mem[idx_hi];
    mask8  = {4'b0000, len_mask} << off_q;
    wd64   = {32'b0, wdata_q} << {off_q, 3'b000};
    be0    = mask8[3:0];
    be1    = mask8[7:4];
    wr0    = wd64[31:0];
    wr1    = wd64[63:32];
`else
    be0    = 4'(len_mask << off_q);
    wr0    = wdata_q << {off_q, 3'b000};
`endif
  end

  // Next-state, request capture and response formation.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    sign_d      = sign_q;
    idx_d       = idx_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef SR_DMEM_SPLIT_EN
    split_d     = split_q;
    lo_d        = lo_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d       = bus.req_we;
          size_d     = bus.req_size;
          sign_d     = bus.req_sign;
          idx_d      = bus.req_addr[AW+1:2];
          off_d      = bus.req_addr[1:0];
          wdata_d    = bus.req_wdata;
          err_d      = req_err;
`ifdef SR_DMEM_SPLIT_EN
          split_d    = misaligned && !req_err;
`endif
          wait_cnt_d = 4'(WAIT_STATES);
          state_d    = (WAIT_STATES == 0) ? ST_BEAT0 : ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (wait_cnt_q <= 4'd1) begin
          wait_cnt_d = 4'd0;
          state_d    = ST_BEAT0;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      ST_BEAT0: begin
`ifdef SR_DMEM_SPLIT_EN
        lo_d = rd0;
        if (split_q) begin
          state_d = ST_BEAT1;
        end else
`endif
        begin
          state_d     = ST_RESP;
          rsp_err_d   = err_q;
          rsp_rdata_d = (err_q || we_q) ? 32'd0
                                        : load_result({32'b0, rd0}, off_q, size_q, sign_q);
        end
      end

`ifdef SR_DMEM_SPLIT_EN
      ST_BEAT1: begin
        state_d     = ST_RESP;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = we_q ? 32'd0 : load_result({rd1, lo_q}, off_q, size_q, sign_q);
      end
`endif

      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured-request registers; reset returns to IDLE and drops
  // any in-flight request or pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      sign_q      <= 1'b0;
      idx_q       <= '0;
      off_q       <= 2'b00;
      wdata_q     <= 32'd0;
      err_q       <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
`ifdef SR_DMEM_SPLIT_EN
      split_q     <= 1'b0;
      lo_q        <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      idx_q       <= idx_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef SR_DMEM_SPLIT_EN
      split_q     <= split_d;
      lo_q        <= lo_d;
`endif
    end
  end

  // Byte-lane writes on the beat edges; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_BEAT0 && we_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be0[b]) mem[idx_q][8*b +: 8] <= wr0[8*b +: 8];
      end
    end
`ifdef SR_DMEM_SPLIT_EN
    if (state_q == ST_BEAT1 && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be1[b]) mem[idx_hi][8*b +: 8] <= wr1[8*b +: 8];
      end
    end
`endif
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dbg_state     = state_q;

endmodule
